// File: rtl/ps2_scancode_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_scancode_fifo_if
//  Description : 32-bit WISHBONE-style register bus between CPU and keyboard
//                event buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps2_scancode_fifo_if;
    logic        cs_i;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic [31:0] adr_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack_o;

    modport master (
        output cs_i, cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        input  dat_o, ack_o
    );

    modport slave (
        input  cs_i, cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        output dat_o, ack_o
    );
endinterface
`default_nettype wire

// File: rtl/ps2_scancode_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_scancode_fifo
//  Description : Folds PS/2 E0/F0 prefixes into 16-bit key events, tracks
//                Shift/Ctrl/Alt and queues events for CPU readout.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_scancode_fifo #(
    parameter int   FIFO_AW   = 4,
    parameter logic pAckStyle = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               sc_valid_i,
    input  logic [7:0]         sc_i,
    input  logic               sc_perr_i,
    ps2_scancode_fifo_if.slave bus,
    output logic               irq
);

    localparam int c_DEPTH = 1 << FIFO_AW;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_EXT     = 2'd1;
    localparam logic [1:0] S_BRK     = 2'd2;
    localparam logic [1:0] S_EXT_BRK = 2'd3;

    localparam logic [7:0] c_PFX_EXT    = 8'hE0;
    localparam logic [7:0] c_PFX_BRK    = 8'hF0;
    localparam logic [7:0] c_KEY_LSHIFT = 8'h12;
    localparam logic [7:0] c_KEY_RSHIFT = 8'h59;
    localparam logic [7:0] c_KEY_CTRL   = 8'h14;
    localparam logic [7:0] c_KEY_ALT    = 8'h11;

    localparam logic [1:0] c_REG_DATA   = 2'd0;
    localparam logic [1:0] c_REG_STATUS = 2'd1;
    localparam logic [1:0] c_REG_CTRL   = 2'd2;
    localparam logic [1:0] c_REG_PEEK   = 2'd3;

    localparam logic [FIFO_AW-1:0] c_PTR_ONE = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   c_CNT_ONE = (FIFO_AW+1)'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic               r_shift;
    logic               r_ctrl;
    logic               r_alt;
    logic               r_ovf;
    logic [7:0]         r_perr_cnt;
    logic               r_ien;
    logic [15:0]        r_mem [0:c_DEPTH-1];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_sel_d;
    logic               r_ack;
    logic [31:0]        r_dat;

    // ------------------------------------------------------------------
    // Bus decode: side effects only on the first cycle of a selection
    // ------------------------------------------------------------------
    logic       w_sel;
    logic       w_sel_rise;
    logic [1:0] w_reg;
    logic       w_wr;
    logic       w_rd;
    logic       w_flush;
    logic       w_clr_err;
    logic       w_ctrl_wr;
    logic       w_pop;
    logic       w_empty;
    logic       w_full;

    assign w_sel      = bus.cs_i & bus.cyc_i & bus.stb_i;
    assign w_sel_rise = w_sel & ~r_sel_d;
    assign w_reg      = bus.adr_i[3:2];
    assign w_wr       = w_sel_rise & bus.we_i & bus.sel_i[0];
    assign w_rd       = w_sel_rise & ~bus.we_i;
    assign w_flush    = w_wr & (w_reg == c_REG_STATUS) & bus.dat_i[0];
    assign w_clr_err  = w_wr & (w_reg == c_REG_STATUS) & bus.dat_i[1];
    assign w_ctrl_wr  = w_wr & (w_reg == c_REG_CTRL);
    assign w_pop      = w_rd & (w_reg == c_REG_DATA) & ~w_empty;

    assign w_empty = (r_count == '0);
    assign w_full  = r_count[FIFO_AW];

    logic w_unused;
    assign w_unused = ^{bus.adr_i[31:4], bus.adr_i[1:0], bus.dat_i[31:2], bus.sel_i[3:1]};

    // ------------------------------------------------------------------
    // Prefix FSM
    // ------------------------------------------------------------------
    logic [1:0] w_state_nx;
    logic       w_emit;
    logic       w_is_pfx;
    logic       w_evt_brk;
    logic       w_evt_ext;

    assign w_is_pfx  = (sc_i == c_PFX_EXT) | (sc_i == c_PFX_BRK);
    assign w_evt_brk = (r_state == S_BRK) | (r_state == S_EXT_BRK);
    assign w_evt_ext = (r_state == S_EXT) | (r_state == S_EXT_BRK);

    always_comb begin
        w_state_nx = r_state;
        w_emit     = 1'b0;
        if (sc_valid_i) begin
            if (sc_perr_i) begin
                w_state_nx = S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (sc_i == c_PFX_EXT) begin
                            w_state_nx = S_EXT;
                        end else if (sc_i == c_PFX_BRK) begin
                            w_state_nx = S_BRK;
                        end else begin
                            w_emit = 1'b1;
                        end
                    end
                    S_EXT: begin
                        if (sc_i == c_PFX_BRK) begin
                            w_state_nx = S_EXT_BRK;
                        end else if (sc_i == c_PFX_EXT) begin
                            w_state_nx = S_EXT;
                        end else begin
                            w_emit     = 1'b1;
                            w_state_nx = S_IDLE;
                        end
                    end
                    S_BRK: begin
                        if (w_is_pfx) begin
                            w_state_nx = S_EXT_BRK;
                        end else begin
                            w_emit     = 1'b1;
                            w_state_nx = S_IDLE;
                        end
                    end
                    default: begin
                        if (!w_is_pfx) begin
                            w_emit     = 1'b1;
                            w_state_nx = S_IDLE;
                        end
                    end
                endcase
            end
        end
        if (w_flush) begin
            w_state_nx = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Modifier tracking; the event carries the post-update state
    // ------------------------------------------------------------------
    logic w_shift_nx;
    logic w_ctrl_nx;
    logic w_alt_nx;

    always_comb begin
        w_shift_nx = r_shift;
        w_ctrl_nx  = r_ctrl;
        w_alt_nx   = r_alt;
        if (w_emit) begin
            if (!w_evt_ext && ((sc_i == c_KEY_LSHIFT) || (sc_i == c_KEY_RSHIFT))) begin
                w_shift_nx = ~w_evt_brk;
            end
            if (sc_i == c_KEY_CTRL) begin
                w_ctrl_nx = ~w_evt_brk;
            end
            if (sc_i == c_KEY_ALT) begin
                w_alt_nx = ~w_evt_brk;
            end
        end
    end

    logic [15:0] w_event;
    logic        w_push;
    logic        w_ovf_set;

    assign w_event   = {w_evt_brk, w_evt_ext, w_shift_nx, w_ctrl_nx, w_alt_nx, 3'b000, sc_i};
    // Fullness is judged before any same-cycle pop; a flush discards the event
    assign w_push    = w_emit & ~w_full & ~w_flush;
    assign w_ovf_set = w_emit &  w_full & ~w_flush;

    // ------------------------------------------------------------------
    // Control/status registers and FIFO pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_shift    <= 1'b0;
            r_ctrl     <= 1'b0;
            r_alt      <= 1'b0;
            r_ovf      <= 1'b0;
            r_perr_cnt <= 8'h00;
            r_ien      <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_shift <= w_shift_nx;
            r_ctrl  <= w_ctrl_nx;
            r_alt   <= w_alt_nx;

            if (w_clr_err) begin
                r_ovf <= 1'b0;
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end

            if (w_clr_err) begin
                r_perr_cnt <= 8'h00;
            end else if (sc_valid_i && sc_perr_i && (r_perr_cnt != 8'hFF)) begin
                r_perr_cnt <= r_perr_cnt + 8'h01;
            end

            if (w_ctrl_wr) begin
                r_ien <= bus.dat_i[0];
            end

            if (w_flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + c_PTR_ONE;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + c_PTR_ONE;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_CNT_ONE;
                    2'b01:   r_count <= r_count - c_CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_event;
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [31:0] w_data_word;
    logic [31:0] w_status;
    logic [31:0] w_rdata;

    assign w_data_word = w_empty ? 32'h0000_0000 : {1'b1, 15'b0, r_mem[r_rptr]};

    always_comb begin
        w_status                = '0;
        w_status[FIFO_AW:0]     = r_count;
        w_status[8]             = w_empty;
        w_status[9]             = w_full;
        w_status[10]            = r_ovf;
        w_status[13:11]         = {r_shift, r_ctrl, r_alt};
        w_status[23:16]         = r_perr_cnt;
    end

    always_comb begin
        case (w_reg)
            c_REG_DATA:   w_rdata = w_data_word;
            c_REG_STATUS: w_rdata = w_status;
            c_REG_CTRL:   w_rdata = {31'b0, r_ien};
            c_REG_PEEK:   w_rdata = w_data_word;
            default:      w_rdata = 32'h0000_0000;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus response; a selection spanning reset is treated as already seen
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        r_sel_d <= w_sel;
        if (rst_i) begin
            r_ack <= 1'b0;
            r_dat <= 32'h0000_0000;
        end else begin
            r_ack <= w_sel ? 1'b1 : pAckStyle;
            if (!w_sel) begin
                r_dat <= 32'h0000_0000;
            end else if (w_sel_rise) begin
                r_dat <= w_rdata;
            end
        end
    end

    assign bus.ack_o = r_ack;
    assign bus.dat_o = r_dat;
    assign irq       = r_ien & ~w_empty;

endmodule
`default_nettype wire
